multicycle_controller: RTL and testbench

- Moore-style main FSM plus ALU decoder for the multicycle RV32I core.
- Sits directly upstream of the multicycle datapath. Consumes op/funct3/funct7b5 from the instruction register and Zero from the ALU.
- Drives every datapath mux select and write enable, one instruction phase per cycle.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal. Any other opcode traps.

---
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller.sv | 179 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction-field inputs and datapath control outputs
// of the multicycle RV32I controller.
interface multicycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               Zero;
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ImmSrc;
  logic               RegWrite;
  logic [2:0]         ALUControl;
  logic               illegal_instr;
  logic [STATE_W-1:0] state_dbg;

  // master: the side that supplies instruction fields (datapath / bench)
  modport master (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, illegal_instr, state_dbg
  );

  modport slave (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, illegal_instr, state_dbg
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore main FSM, immediate decoder and ALU decoder
// for the multicycle RV32I core.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.slave  bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  state_t     state_q;
  state_t     nxt;
  state_t     tgt;
  logic [3:0] state_bits;

  logic       pc_write_q;
  logic       branch_q;
  logic       adr_src_q;
  logic       mem_write_q;
  logic       ir_write_q;
  logic       reg_write_q;
  logic       illegal_q;
  logic [1:0] result_src_q;
  logic [1:0] alu_src_a_q;
  logic [1:0] alu_src_b_q;
  logic [1:0] alu_op_q;
  logic [1:0] alu_op;

  always_comb begin
    nxt = state_q;
    case (state_q)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYP:      nxt = S_EXECR;
          OP_ITYP:      nxt = S_EXECI;
          OP_JAL:       nxt = S_JAL;
          OP_BEQ:       nxt = S_BEQ;
          default:      nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:                        nxt = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:                       nxt = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL:         nxt = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB,
      S_BEQ:                           nxt = S_FETCH;
      S_ILLEGAL:                       nxt = S_ILLEGAL;
      default:                         nxt = S_FETCH;
    endcase
    tgt = reset ? S_FETCH : nxt;
  end

  // Outputs are registered from the state being entered, so they line up with state_q.
  always_ff @(posedge clk) begin
    state_q      <= tgt;
    pc_write_q   <= 1'b0;
    branch_q     <= 1'b0;
    adr_src_q    <= 1'b0;
    mem_write_q  <= 1'b0;
    ir_write_q   <= 1'b0;
    reg_write_q  <= 1'b0;
    illegal_q    <= 1'b0;
    result_src_q <= 2'b00;
    alu_src_a_q  <= 2'b00;
    alu_src_b_q  <= 2'b00;
    alu_op_q     <= 2'b00;
    case (tgt)
      S_FETCH: begin
        ir_write_q   <= 1'b1;
        pc_write_q   <= 1'b1;
        alu_src_b_q  <= 2'b10;
        result_src_q <= 2'b10;
      end
      S_DECODE: begin
        alu_src_a_q <= 2'b01;
        alu_src_b_q <= 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_q <= 2'b10;
        alu_src_b_q <= 2'b01;
      end
      S_MEMREAD: adr_src_q <= 1'b1;
      S_MEMWB: begin
        result_src_q <= 2'b01;
        reg_write_q  <= 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_q   <= 1'b1;
        mem_write_q <= 1'b1;
      end
      S_EXECR: begin
        alu_src_a_q <= 2'b10;
        alu_op_q    <= 2'b10;
      end
      S_EXECI: begin
        alu_src_a_q <= 2'b10;
        alu_src_b_q <= 2'b01;
        alu_op_q    <= 2'b10;
      end
      S_ALUWB: reg_write_q <= 1'b1;
      S_JAL: begin
        alu_src_a_q <= 2'b01;
        alu_src_b_q <= 2'b10;
        pc_write_q  <= 1'b1;
      end
      S_BEQ: begin
        alu_src_a_q <= 2'b10;
        alu_op_q    <= 2'b01;
        branch_q    <= 1'b1;
      end
      S_ILLEGAL: illegal_q <= 1'b1;
      default: ;
    endcase
  end

  // Reset overrides the registered outputs in the same cycle it is seen.
  assign bus.PCWrite       = ~reset & (pc_write_q | (branch_q & bus.Zero));
  assign bus.IRWrite       = ~reset & ir_write_q;
  assign bus.RegWrite      = ~reset & reg_write_q;
  assign bus.MemWrite      = ~reset & mem_write_q;
  assign bus.AdrSrc        = ~reset & adr_src_q;
  assign bus.illegal_instr = ~reset & illegal_q;
  assign bus.ResultSrc     = reset ? 2'b10 : result_src_q;
  assign bus.ALUSrcA       = reset ? 2'b00 : alu_src_a_q;
  assign bus.ALUSrcB       = reset ? 2'b10 : alu_src_b_q;
  assign alu_op            = reset ? 2'b00 : alu_op_q;
  assign state_bits        = state_q;
  assign bus.state_dbg     = reset ? '0 : STATE_W'(state_bits);

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BEQ:  bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    bus.ALUControl = 3'b000;
    case (alu_op)
      2'b01: bus.ALUControl = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  bus.ALUControl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  bus.ALUControl = 3'b101;
          3'b110:  bus.ALUControl = 3'b011;
          3'b111:  bus.ALUControl = 3'b010;
          default: bus.ALUControl = 3'b000;
        endcase
      end
      default: bus.ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - table-driven cycle checks plus CPI sequences
// for multicycle_controller.
module tb_multicycle_controller;

  logic clk;
  logic reset;

  multicycle_controller_if #(.STATE_W(4)) bus ();

  multicycle_controller #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] BQ = 7'b1100011;
  localparam logic [6:0] XX = 7'b0000000;

  // exp = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal,
  //        ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl}
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input logic [3:0] st, input logic [5:0] en,
                     input logic [1:0] res, input logic [1:0] asa, input logic [1:0] asb,
                     input logic [1:0] imm, input logic [2:0] aluc);
    vec_t v;
    v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z;
    v.exp = {st, en, res, asa, asb, imm, aluc};
    vecs.push_back(v);
  endtask

  function automatic logic [20:0] got_outputs();
    return {bus.state_dbg[3:0], bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
            bus.RegWrite, bus.illegal_instr, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
            bus.ImmSrc, bus.ALUControl};
  endfunction

  task automatic run_cpi(input logic [6:0] o, input logic [2:0] f3, input int expected, input string name);
    int n;
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = 1'b0; bus.Zero = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.state_dbg != 4'd0 && n < 20);
    checks++;
    if (n != expected) begin
      failures++;
      $display("FAIL cpi_%s: cycles=%0d expected=%0d", name, n, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.op = LW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;

    //  rst   op  f3      f7    z     st     en         res    asa    asb    imm    aluc
    add(1'b1, LW, 3'b010, 1'b0, 1'b0, 4'd0,  6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add(1'b1, LW, 3'b010, 1'b0, 1'b0, 4'd0,  6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    // lw
    add(1'b0, LW, 3'b010, 1'b0, 1'b0, 4'd0,  6'b100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add(1'b0, LW, 3'b010, 1'b0, 1'b0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    add(1'b0, LW, 3'b010, 1'b0, 1'b0, 4'd2,  6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    add(1'b0, LW, 3'b010, 1'b0, 1'b0, 4'd3,  6'b010000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    add(1'b0, LW, 3'b010, 1'b0, 1'b0, 4'd4,  6'b000010, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
    // sw
    add(1'b0, SW, 3'b010, 1'b0, 1'b0, 4'd0,  6'b100100, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
    add(1'b0, SW, 3'b010, 1'b0, 1'b0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000);
    add(1'b0, SW, 3'b010, 1'b0, 1'b0, 4'd2,  6'b000000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000);
    add(1'b0, SW, 3'b010, 1'b0, 1'b0, 4'd5,  6'b011000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
    // sub
    add(1'b0, RT, 3'b000, 1'b1, 1'b0, 4'd0,  6'b100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add(1'b0, RT, 3'b000, 1'b1, 1'b0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    add(1'b0, RT, 3'b000, 1'b1, 1'b0, 4'd6,  6'b000000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    add(1'b0, RT, 3'b000, 1'b1, 1'b0, 4'd7,  6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    // and
    add(1'b0, RT, 3'b111, 1'b0, 1'b0, 4'd0,  6'b100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add(1'b0, RT, 3'b111, 1'b0, 1'b0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    add(1'b0, RT, 3'b111, 1'b0, 1'b0, 4'd6,  6'b000000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010);
    add(1'b0, RT, 3'b111, 1'b0, 1'b0, 4'd7,  6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    // slt
    add(1'b0, RT, 3'b010, 1'b0, 1'b0, 4'd0,  6'b100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add(1'b0, RT, 3'b010, 1'b0, 1'b0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    add(1'b0, RT, 3'b010, 1'b0, 1'b0, 4'd6,  6'b000000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101);
    add(1'b0, RT, 3'b010, 1'b0, 1'b0, 4'd7,  6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    // addi with funct7b5=1 stays add; op changes in ALUWB are ignored
    add(1'b0, IT, 3'b000, 1'b1, 1'b0, 4'd0,  6'b100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add(1'b0, IT, 3'b000, 1'b1, 1'b0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    add(1'b0, IT, 3'b000, 1'b1, 1'b0, 4'd8,  6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    add(1'b0, XX, 3'b000, 1'b1, 1'b0, 4'd7,  6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    // jal
    add(1'b0, JL, 3'b000, 1'b0, 1'b0, 4'd0,  6'b100100, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000);
    add(1'b0, JL, 3'b000, 1'b0, 1'b0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000);
    add(1'b0, JL, 3'b000, 1'b0, 1'b0, 4'd9,  6'b100000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000);
    add(1'b0, JL, 3'b000, 1'b0, 1'b0, 4'd7,  6'b000010, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000);
    // beq taken
    add(1'b0, BQ, 3'b000, 1'b0, 1'b1, 4'd0,  6'b100100, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000);
    add(1'b0, BQ, 3'b000, 1'b0, 1'b1, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000);
    add(1'b0, BQ, 3'b000, 1'b0, 1'b1, 4'd10, 6'b100000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
    // beq not taken; Zero=1 outside BEQ must not raise PCWrite
    add(1'b0, BQ, 3'b000, 1'b0, 1'b0, 4'd0,  6'b100100, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000);
    add(1'b0, BQ, 3'b000, 1'b0, 1'b1, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000);
    add(1'b0, BQ, 3'b000, 1'b0, 1'b0, 4'd10, 6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
    // illegal opcode traps and holds
    add(1'b0, XX, 3'b000, 1'b0, 1'b0, 4'd0,  6'b100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add(1'b0, XX, 3'b000, 1'b0, 1'b0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    for (int i = 0; i < 10; i++)
      add(1'b0, (i % 2 == 0) ? LW : RT, 3'b000, 1'b0, 1'b1, 4'd11, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    add(1'b1, XX, 3'b000, 1'b0, 1'b0, 4'd0,  6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    // reset during MEMWRITE
    add(1'b0, SW, 3'b010, 1'b0, 1'b0, 4'd0,  6'b100100, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
    add(1'b0, SW, 3'b010, 1'b0, 1'b0, 4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000);
    add(1'b0, SW, 3'b010, 1'b0, 1'b0, 4'd2,  6'b000000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000);
    add(1'b1, SW, 3'b010, 1'b0, 1'b0, 4'd0,  6'b000000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
    add(1'b0, SW, 3'b010, 1'b0, 1'b0, 4'd0,  6'b100100, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [20:0] got;
      @(negedge clk);
      reset = vecs[i].rst;
      bus.op = vecs[i].op; bus.funct3 = vecs[i].f3;
      bus.funct7b5 = vecs[i].f7; bus.Zero = vecs[i].z;
      #1;
      got = got_outputs();
      checks++;
      if (got !== vecs[i].exp) begin
        failures++;
        $display("FAIL vec%0d: got=%06h expected=%06h", i, got, vecs[i].exp);
      end
    end

    // Still inside the final FETCH cycle: measure cycles per instruction.
    run_cpi(LW, 3'b010, 5, "lw");
    run_cpi(SW, 3'b010, 4, "sw");
    run_cpi(RT, 3'b000, 4, "rtype");
    run_cpi(IT, 3'b000, 4, "itype");
    run_cpi(JL, 3'b000, 4, "jal");
    run_cpi(BQ, 3'b000, 3, "beq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
